// File: rtl/fp_cmp_pkg.sv
// ---------------------------------------------------------------------------
// fp_cmp_pkg
// Shared definitions for the pipelined FloPoCo-format comparator.
//   * Exception codes of the {exc[1:0], sign, exponent, fraction} format.
//   * Compare-mode encodings carried on in_op.
//   * Width derivation helpers (operand width W, magnitude key width MAG_W).
//   * cmp_decide(): maps (mode, less-than, equal, unordered) to the result bit.
// ---------------------------------------------------------------------------
package fp_cmp_pkg;

   // Exception field encodings
   localparam logic [1:0] EXC_ZERO = 2'b00;
   localparam logic [1:0] EXC_NORM = 2'b01;
   localparam logic [1:0] EXC_INF  = 2'b10;
   localparam logic [1:0] EXC_NAN  = 2'b11;

   // Compare modes; 3'b110 and 3'b111 are reserved and always yield 0
   localparam logic [2:0] OP_GT = 3'b000;
   localparam logic [2:0] OP_GE = 3'b001;
   localparam logic [2:0] OP_LT = 3'b010;
   localparam logic [2:0] OP_LE = 3'b011;
   localparam logic [2:0] OP_EQ = 3'b100;
   localparam logic [2:0] OP_NE = 3'b101;

   // Full operand width: exc(2) + sign(1) + exponent + fraction
   function automatic int fp_width(input int we, input int wf);
      return we + wf + 3;
   endfunction

   // Unsigned magnitude key width: class(2) + exponent + fraction
   function automatic int mag_width(input int we, input int wf);
      return we + wf + 2;
   endfunction

   // Result bit for one compare. An unordered pair is "not equal" and
   // nothing else, so only NE reports true in that case.
   function automatic logic cmp_decide(input logic [2:0] op,
                                       input logic       lt,
                                       input logic       eq,
                                       input logic       unord);
      logic r;
      r = 1'b0;
      if (unord) begin
         r = (op == OP_NE);
      end else begin
         case (op)
            OP_GT:   r = !lt && !eq;
            OP_GE:   r = !lt;
            OP_LT:   r = lt;
            OP_LE:   r = lt || eq;
            OP_EQ:   r = eq;
            OP_NE:   r = !eq;
            default: r = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_order_key.sv
// ---------------------------------------------------------------------------
// fp_order_key
// Combinational conversion of one FloPoCo operand into a two's-complement
// ordering key, so that a plain signed compare of two keys orders the
// operands. Also flags NaN operands.
//
// Ports:
//   opnd    in   W        operand {exc, sign, exponent, fraction}
//   key     out  MAG_W+1  signed ordering key (0 for either zero)
//   is_nan  out  1        operand exception code is NaN
// ---------------------------------------------------------------------------
module fp_order_key
   import fp_cmp_pkg::*;
#(
   parameter  int WE    = 11,
   parameter  int WF    = 13,
   localparam int W     = fp_width(WE, WF),
   localparam int MAG_W = mag_width(WE, WF)
) (
   input  logic [W-1:0]   opnd,
   output logic [MAG_W:0] key,
   output logic           is_nan
);

   logic [1:0]       exc_s;
   logic             sign_s;
   logic [MAG_W-1:0] mag_s;

   assign exc_s  = opnd[W-1 -: 2];
   assign sign_s = opnd[W-3];
   assign is_nan = (exc_s == EXC_NAN);

   // Build the unsigned magnitude: class rank on top, then exponent/fraction.
   // Infinity outranks every normal because its top bits are 2'b10.
   always_comb begin
      mag_s = {MAG_W{1'b0}};
      case (exc_s)
         EXC_ZERO: mag_s = {MAG_W{1'b0}};
         EXC_NORM: mag_s = {2'b01, opnd[WE+WF-1:0]};
         EXC_INF:  mag_s = {2'b10, {(WE+WF){1'b0}}};
         default:  mag_s = {MAG_W{1'b0}};
      endcase
   end

   // Negate for negative operands; -0 negates to 0 so both zeros compare equal.
   always_comb begin
      key = {1'b0, mag_s};
      if (sign_s) begin
         key = {(MAG_W+1){1'b0}} - {1'b0, mag_s};
      end else begin
         key = {1'b0, mag_s};
      end
   end

endmodule

// File: rtl/fp_compare_pipe.sv
// ---------------------------------------------------------------------------
// fp_compare_pipe
// Pipelined floating-point comparator with per-transaction compare mode,
// valid/ready flow control, tag pass-through and NaN reporting.
//
//   Stage 1     : both ordering keys, mode, NaN flag, tag.
//   Stage 2     : compare result (signed key compare, no subtractor).
//   Stage 3..LAT: pure delay. LAT must lie in 2..6.
//
// The whole pipeline advances together under en = !out_valid | out_ready,
// so a held output freezes every stage and in_ready mirrors en.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand-pair handshake
//   in_a, in_b            operands (W bits each)
//   in_op                 compare mode (GT, GE, LT, LE, EQ, NE; 110/111 -> 0)
//   in_tag                opaque tag
//   out_valid/out_ready   result handshake
//   out_res               compare result
//   out_unord             at least one operand was NaN
//   out_tag               tag of this result
//   nan_sticky            set by any accepted NaN result
//   clr_sticky            synchronous clear of nan_sticky (set wins)
// ---------------------------------------------------------------------------
module fp_compare_pipe
   import fp_cmp_pkg::*;
#(
   parameter  int WE    = 11,
   parameter  int WF    = 13,
   parameter  int LAT   = 2,
   parameter  int TAG_W = 4,
   localparam int W     = fp_width(WE, WF),
   localparam int MAG_W = mag_width(WE, WF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_res,
   output logic             out_unord,
   output logic [TAG_W-1:0] out_tag,
   output logic             nan_sticky,
   input  logic             clr_sticky
);

   logic             en_s;
   logic [MAG_W:0]   key_a_s;
   logic [MAG_W:0]   key_b_s;
   logic             nan_a_s;
   logic             nan_b_s;

   // Stage 1 registers
   logic             s1_valid_r;
   logic [MAG_W:0]   s1_key_a_r;
   logic [MAG_W:0]   s1_key_b_r;
   logic [2:0]       s1_op_r;
   logic             s1_unord_r;
   logic [TAG_W-1:0] s1_tag_r;

   // Stage 2..LAT registers; index LAT drives the outputs
   logic             pv_r     [2:LAT];
   logic             pres_r   [2:LAT];
   logic             punord_r [2:LAT];
   logic [TAG_W-1:0] ptag_r   [2:LAT];

   logic             lt_s;
   logic             eq_s;
   logic             res_s;
   logic             out_hs_s;

   assign en_s     = !out_valid || out_ready;
   assign in_ready = en_s;
   assign out_hs_s = out_valid && out_ready;

   fp_order_key #(.WE(WE), .WF(WF)) u_key_a (
      .opnd   (in_a),
      .key    (key_a_s),
      .is_nan (nan_a_s)
   );

   fp_order_key #(.WE(WE), .WF(WF)) u_key_b (
      .opnd   (in_b),
      .key    (key_b_s),
      .is_nan (nan_b_s)
   );

   // Stage 1: capture keys and sideband; a bubble enters with valid low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_key_a_r <= {(MAG_W+1){1'b0}};
         s1_key_b_r <= {(MAG_W+1){1'b0}};
         s1_op_r    <= 3'b000;
         s1_unord_r <= 1'b0;
         s1_tag_r   <= {TAG_W{1'b0}};
      end else if (en_s) begin
         s1_valid_r <= in_valid;
         s1_key_a_r <= key_a_s;
         s1_key_b_r <= key_b_s;
         s1_op_r    <= in_op;
         s1_unord_r <= nan_a_s || nan_b_s;
         s1_tag_r   <= in_tag;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // Stage-2 compare: signed key ordering decides lt/eq for every mode.
   always_comb begin
      lt_s  = ($signed(s1_key_a_r) < $signed(s1_key_b_r));
      eq_s  = (s1_key_a_r == s1_key_b_r);
      res_s = cmp_decide(s1_op_r, lt_s, eq_s, s1_unord_r);
   end

   // Stage 2 and delay stages. Data is zeroed on a bubble at stage 2 so
   // every output reads 0 whenever out_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 2; k <= LAT; k++) begin
            pv_r[k]     <= 1'b0;
            pres_r[k]   <= 1'b0;
            punord_r[k] <= 1'b0;
            ptag_r[k]   <= {TAG_W{1'b0}};
         end
      end else if (en_s) begin
         pv_r[2]     <= s1_valid_r;
         pres_r[2]   <= s1_valid_r && res_s;
         punord_r[2] <= s1_valid_r && s1_unord_r;
         ptag_r[2]   <= s1_valid_r ? s1_tag_r : {TAG_W{1'b0}};
         for (int k = 3; k <= LAT; k++) begin
            pv_r[k]     <= pv_r[k-1];
            pres_r[k]   <= pres_r[k-1];
            punord_r[k] <= punord_r[k-1];
            ptag_r[k]   <= ptag_r[k-1];
         end
      end else begin
         pv_r[2] <= pv_r[2];
      end
   end

   assign out_valid = pv_r[LAT];
   assign out_res   = pres_r[LAT];
   assign out_unord = punord_r[LAT];
   assign out_tag   = ptag_r[LAT];

   // NaN sticky flag: a NaN result leaving the block takes priority over clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nan_sticky <= 1'b0;
      end else if (out_hs_s && out_unord) begin
         nan_sticky <= 1'b1;
      end else if (clr_sticky) begin
         nan_sticky <= 1'b0;
      end else begin
         nan_sticky <= nan_sticky;
      end
   end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_compare_pipe
// Self-checking bench: directed cases plus randomized traffic compared
// against a value-level ordering model and an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_fp_compare_pipe;

   localparam int WE    = 11;
   localparam int WF    = 13;
   localparam int LAT   = 2;
   localparam int TAG_W = 4;
   localparam int W     = WE + WF + 3;

   localparam logic [2:0] M_GT = 3'd0;
   localparam logic [2:0] M_GE = 3'd1;
   localparam logic [2:0] M_LT = 3'd2;
   localparam logic [2:0] M_LE = 3'd3;
   localparam logic [2:0] M_EQ = 3'd4;
   localparam logic [2:0] M_NE = 3'd5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic             out_res;
   logic             out_unord;
   logic [TAG_W-1:0] out_tag;
   logic             nan_sticky;
   logic             clr_sticky;

   always #5 clk = ~clk;

   fp_compare_pipe #(.WE(WE), .WF(WF), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_res    (out_res),
      .out_unord  (out_unord),
      .out_tag    (out_tag),
      .nan_sticky (nan_sticky),
      .clr_sticky (clr_sticky)
   );

   typedef struct packed {
      logic             res;
      logic             unord;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             exp_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               n_out    = 0;
   logic             exp_sticky = 1'b0;
   logic             held_v = 1'b0;
   logic             held_res;
   logic             held_unord;
   logic [TAG_W-1:0] held_tag;
   logic             last_acc;
   logic             saw_stall;

   task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, obs, req, $time);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [1:0] exc, input logic s,
                                       input logic [WE-1:0] e, input logic [WF-1:0] f);
      return {exc, s, e, f};
   endfunction

   // -1 negative, 0 zero, +1 positive (zeros are unsigned)
   function automatic int side(input logic [W-1:0] x);
      if (x[W-1:W-2] == 2'b00) return 0;
      return x[W-3] ? -1 : 1;
   endfunction

   // Compare absolute values of two non-zero, non-NaN operands
   function automatic int mag_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
      int ra, rb;
      ra = (a[W-1:W-2] == 2'b10) ? 2 : 1;
      rb = (b[W-1:W-2] == 2'b10) ? 2 : 1;
      if (ra != rb) return (ra < rb) ? -1 : 1;
      if (ra == 2) return 0;
      if (a[WE+WF-1:WF] != b[WE+WF-1:WF]) return (a[WE+WF-1:WF] < b[WE+WF-1:WF]) ? -1 : 1;
      if (a[WF-1:0] != b[WF-1:0]) return (a[WF-1:0] < b[WF-1:0]) ? -1 : 1;
      return 0;
   endfunction

   function automatic int order(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb;
      sa = side(a);
      sb = side(b);
      if (sa != sb) return (sa < sb) ? -1 : 1;
      if (sa == 0) return 0;
      return sa * mag_cmp(a, b);
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op, input logic [TAG_W-1:0] tag);
      exp_t e;
      int   o;
      e.tag   = tag;
      e.unord = (a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11);
      if (e.unord) begin
         e.res = (op == M_NE);
      end else begin
         o = order(a, b);
         case (op)
            M_GT:    e.res = (o > 0);
            M_GE:    e.res = (o >= 0);
            M_LT:    e.res = (o < 0);
            M_LE:    e.res = (o <= 0);
            M_EQ:    e.res = (o == 0);
            M_NE:    e.res = (o != 0);
            default: e.res = 1'b0;
         endcase
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_opnd();
      logic [1:0]    exc;
      logic [WE-1:0] e;
      logic [WF-1:0] f;
      int            r;
      r = $urandom_range(0, 9);
      exc = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b01;
      r = $urandom_range(0, 2);
      e = (r == 0) ? 11'h3FF : (r == 1) ? 11'h400 : WE'($urandom);
      r = $urandom_range(0, 2);
      f = (r == 0) ? 13'h0 : (r == 1) ? 13'h1 : WF'($urandom);
      return mk(exc, 1'($urandom), e, f);
   endfunction

   task automatic rand_pair();
      int r;
      in_a = rand_opnd();
      r = $urandom_range(0, 3);
      if (r == 0) in_b = in_a;
      else if (r == 1) in_b = {in_a[W-1:W-2], ~in_a[W-3], in_a[W-4:0]};
      else in_b = rand_opnd();
      in_op = 3'($urandom_range(0, 7));
   endtask

   // One clock of bookkeeping: output check at negedge, then advance.
   task automatic step();
      exp_t e;
      logic hs_unord;
      @(negedge clk);
      hs_unord = 1'b0;
      check_val("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held_v) begin
         check_val("stall_valid", out_valid, 1'b1);
         check_val("stall_res", out_res, held_res);
         check_val("stall_unord", out_unord, held_unord);
         check_val("stall_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check_val("spurious_out", out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check_val("res", out_res, e.res);
            check_val("unord", out_unord, e.unord);
            check_val("tag", out_tag, e.tag);
            hs_unord = e.unord;
         end
      end
      held_v     = out_valid && !out_ready;
      held_res   = out_res;
      held_unord = out_unord;
      held_tag   = out_tag;
      last_acc   = in_valid && in_ready;
      if (!in_ready) saw_stall = 1'b1;
      if (last_acc) exp_q.push_back(model(in_a, in_b, in_op, in_tag));
      if (hs_unord) exp_sticky = 1'b1;
      else if (clr_sticky) exp_sticky = 1'b0;
      @(posedge clk);
      #1;
      check_val("nan_sticky", nan_sticky, exp_sticky);
   endtask

   task automatic drain();
      int c;
      c = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && c < 50) begin
         step();
         c++;
      end
      check_val("drain_empty", exp_q.size(), 0);
   endtask

   // Single transaction on an idle pipe with latency and result checks.
   task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic [TAG_W-1:0] tag, input logic x_res, input logic x_unord,
                         input logic clr_at_out);
      int lat;
      check_val("idle_before", out_valid, 1'b0);
      in_a = a; in_b = b; in_op = op; in_tag = tag;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      check_val("latency", lat, LAT);
      check_val("dir_res", out_res, x_res);
      check_val("dir_unord", out_unord, x_unord);
      check_val("dir_tag", out_tag, tag);
      clr_sticky = clr_at_out;
      step();
      clr_sticky = 1'b0;
   endtask

   logic [W-1:0] one, two, ntwo, zp, zn, infp, infp2, infn, nan;

   initial begin
      int i, c;
      one   = mk(2'b01, 1'b0, 11'h3FF, 13'h0);
      two   = mk(2'b01, 1'b0, 11'h400, 13'h0);
      ntwo  = mk(2'b01, 1'b1, 11'h400, 13'h0);
      zp    = mk(2'b00, 1'b0, 11'h123, 13'h456);
      zn    = mk(2'b00, 1'b1, 11'h7AB, 13'h0F0);
      infp  = mk(2'b10, 1'b0, 11'h001, 13'h002);
      infp2 = mk(2'b10, 1'b0, 11'h7FF, 13'h1FFF);
      infn  = mk(2'b10, 1'b1, 11'h055, 13'h0AA);
      nan   = mk(2'b11, 1'b0, 11'h3FF, 13'h001);

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 3'd0;
      in_tag = '0; out_ready = 1'b0; clr_sticky = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_out_res", out_res, 1'b0);
      check_val("rst_out_unord", out_unord, 1'b0);
      check_val("rst_out_tag", out_tag, 4'h0);
      check_val("rst_sticky", nan_sticky, 1'b0);
      check_val("rst_in_ready", in_ready, 1'b1);
      rst = 1'b0;

      // Directed ordering cases
      single(two, one, M_GT, 4'd1, 1'b1, 1'b0, 1'b0);
      single(two, one, M_LT, 4'd2, 1'b0, 1'b0, 1'b0);
      single(zp, zn, M_EQ, 4'd3, 1'b1, 1'b0, 1'b0);
      single(zp, zn, M_GT, 4'd4, 1'b0, 1'b0, 1'b0);
      single(zp, zn, M_GE, 4'd5, 1'b1, 1'b0, 1'b0);
      single(ntwo, one, M_LT, 4'd6, 1'b1, 1'b0, 1'b0);
      single(infn, ntwo, M_LT, 4'd7, 1'b1, 1'b0, 1'b0);
      single(infp, infp2, M_EQ, 4'd8, 1'b1, 1'b0, 1'b0);
      single(two, one, 3'b110, 4'd9, 1'b0, 1'b0, 1'b0);
      single(nan, one, 3'b111, 4'd10, 1'b0, 1'b1, 1'b0);
      check_val("sticky_reserved_nan", nan_sticky, 1'b1);

      // NaN handling and sticky flag
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      single(nan, one, M_LE, 4'd11, 1'b0, 1'b1, 1'b0);
      check_val("sticky_set", nan_sticky, 1'b1);
      single(nan, one, M_NE, 4'd12, 1'b1, 1'b1, 1'b0);
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      check_val("sticky_clr", nan_sticky, 1'b0);
      single(one, nan, M_LE, 4'd13, 1'b0, 1'b1, 1'b1);
      check_val("sticky_coinc", nan_sticky, 1'b1);

      // Asynchronous reset with two pairs in flight
      in_a = nan; in_b = one; in_op = M_EQ; out_ready = 1'b1; in_valid = 1'b1;
      in_tag = 4'd14; step();
      in_tag = 4'd15; step();
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check_val("arst_out_valid", out_valid, 1'b0);
      check_val("arst_sticky", nan_sticky, 1'b0);
      check_val("arst_out_tag", out_tag, 4'h0);
      exp_q.delete();
      exp_sticky = 1'b0;
      held_v = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      single(two, two, M_GE, 4'd3, 1'b1, 1'b0, 1'b0);

      // Back-to-back stream with a mid-stream stall
      i = 0; c = 0; saw_stall = 1'b0; n_out = 0;
      while (i < 8 && c < 40) begin
         in_valid  = 1'b1;
         rand_pair();
         in_tag    = 4'(i);
         out_ready = !(c >= 3 && c < 6);
         step();
         if (last_acc) i++;
         c++;
      end
      drain();
      check_val("stream_accepted", i, 8);
      check_val("stream_outputs", n_out, 8);
      check_val("stream_stall_seen", saw_stall, 1'b1);

      // Randomized traffic with random backpressure and clears
      for (int k = 0; k < 400; k++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         clr_sticky = ($urandom_range(0, 15) == 0);
         in_tag     = 4'($urandom);
         rand_pair();
         step();
      end
      clr_sticky = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
